// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader takes the slave view; the host/memory side takes the master view.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 6
);
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads instruction memory from a LEN / data / XOR-checksum byte frame and
// releases the core from reset only after a clean load.
module imem_boot_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     words_loaded
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       csum_q, csum_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              s_ready_q, s_ready_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_hold_q, cpu_hold_d;

    logic              xfer;
    logic              last_byte;
    logic [31:0]       full_word;

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        csum_d      = csum_q;
        n_d         = n_q;
        wl_d        = wl_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // s_ready_q is the registered ready the source sees, so it qualifies the handshake
        xfer      = s_ready_q && bus.s_valid;
        last_byte = xfer && (byte_idx_q == 2'd3);
        full_word = word_q;
        full_word[{byte_idx_q, 3'b000} +: 8] = bus.s_data;

        if (xfer) begin
            byte_idx_d = byte_idx_q + 2'd1;
            word_d     = full_word;
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LEN;
                    byte_idx_d = 2'd0;
                    wl_d       = '0;
                    csum_d     = '0;
                end
            end
            ST_LEN: begin
                if (last_byte) begin
                    if ((full_word == 32'd0) || (full_word > 32'(DEPTH))) begin
                        state_d = ST_ERR;
                    end else begin
                        n_d     = full_word[ADDR_W:0];
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (last_byte) begin
                    state_d     = ST_WRITE;
                    mem_addr_d  = wl_q[ADDR_W-1:0];
                    mem_wdata_d = full_word;
                    csum_d      = csum_q ^ full_word;
                    wl_d        = wl_q + 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = (wl_q == n_q) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                if (last_byte) begin
                    state_d = (full_word == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered decodes of the next state, so they change on the same edge as state
        s_ready_d  = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        mem_we_d   = (state_d == ST_WRITE);
        busy_d     = s_ready_d || mem_we_d;
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERR);
        cpu_hold_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            byte_idx_q  <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            n_q         <= '0;
            wl_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_hold_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            n_q         <= n_d;
            wl_q        <= wl_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            s_ready_q   <= s_ready_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_loaded  = wl_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized frame stimulus; expected imem writes are queued at issue time and
// popped by an independent write monitor.
module tb_imem_boot_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus.slave),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [31:0]        wbuf[DEPTH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_we pulse must match the oldest expected write
    always @(posedge clk) begin
        #1;
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                check("mem_write", 64'({bus.mem_addr, bus.mem_wdata}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int guard;
        guard = 0;
        while ($urandom_range(99) < gap_pct) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (bus.s_ready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            n_tests++;
            n_fail++;
            $display("FAIL s_ready_timeout: got s_ready=%b expected 1 within 1000 cycles", bus.s_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_pct);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_pct);
    endtask

    task automatic pulse_start();
        bus.s_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [31:0] xor_words(input int n);
        logic [31:0] x = 32'd0;
        for (int i = 0; i < n; i++) x ^= wbuf[i];
        return x;
    endfunction

    // Model: a LEN in 1..DEPTH loads every data word in order; success iff C equals their XOR
    task automatic run_frame(input logic [31:0] n_word, input logic [31:0] csum_in,
                             input int gap_pct, input int start_at);
        logic valid;
        int   nw;
        logic exp_done;
        valid    = (n_word != 32'd0) && (n_word <= 32'(DEPTH));
        nw       = valid ? int'(n_word) : 0;
        for (int i = 0; i < nw; i++) exp_q.push_back({ADDR_W'(i), wbuf[i]});
        exp_done = valid && (csum_in == xor_words(nw));

        pulse_start();
        check("busy_after_start", 64'(busy), 64'(1));
        check("hold_after_start", 64'(cpu_hold), 64'(1));
        send_word(n_word, gap_pct);
        if (valid) begin
            for (int i = 0; i < nw; i++) begin
                if (i == start_at) pulse_start();
                send_word(wbuf[i], gap_pct);
            end
            send_word(csum_in, gap_pct);
        end
        bus.s_valid = 1'b0;
        check("done", 64'(done), 64'(exp_done));
        check("error", 64'(error), 64'(!exp_done));
        check("busy_end", 64'(busy), 64'(0));
        check("cpu_hold", 64'(cpu_hold), 64'(!exp_done));
        check("words_loaded", 64'(words_loaded), 64'(nw));
        check("writes_outstanding", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(1));
        check({tag, "_s_ready"}, 64'(bus.s_ready), 64'(0));
        check({tag, "_mem_we"}, 64'(bus.mem_we), 64'(0));
        check({tag, "_flags"}, 64'({done, error, busy}), 64'(0));
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'(0));
        check({tag, "_mem_addr_data"}, 64'({bus.mem_addr, bus.mem_wdata}), 64'(0));
    endtask

    initial begin
        int guard;
        logic [31:0] c;
        reset       = 1'b0;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_idle("reset");
        reset = 1'b1;
        @(negedge clk);

        wbuf[0] = 32'h00000093;
        wbuf[1] = 32'h00100113;
        run_frame(32'd2, 32'h00100180, 0, -1);
        run_frame(32'd2, 32'h00000000, 0, -1);

        run_frame(32'd0, 32'd0, 0, -1);
        run_frame(32'd65, 32'd0, 20, -1);

        for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
        run_frame(32'd64, xor_words(64), 30, 20);

        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(12, 1);
            for (int i = 0; i < n; i++) wbuf[i] = $urandom;
            c = xor_words(n);
            if ($urandom_range(1) == 0) c ^= 32'(1) << $urandom_range(31);
            run_frame(32'(n), c, 25, -1);
        end

        for (int i = 0; i < 3; i++) begin
            wbuf[i] = $urandom;
            exp_q.push_back({ADDR_W'(i), wbuf[i]});
        end
        pulse_start();
        send_word(32'd10, 10);
        for (int i = 0; i < 3; i++) send_word(wbuf[i], 10);
        bus.s_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("partial_writes_outstanding", 64'(exp_q.size()), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check_idle("midload_reset");
        reset = 1'b1;
        @(negedge clk);
        wbuf[0] = $urandom;
        run_frame(32'd1, wbuf[0], 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
